l1_dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate L1 data cache. It sits between the core's load/store stage and the word-addressed `Memory` block. It acts as the initiator of the `ren`/`wen`/`addr`/`din`/`dout` memory protocol and holds the core with `cpu_stall` on misses and writes. Read hits return data in the request cycle. Misses refill a whole block word by word.

---
 rtl/l1_dcache_pkg.sv | 7 +
 rtl/l1_dcache_array.sv | 37 +++
 rtl/l1_dcache.sv | 126 ++++++++++++
 tb/tb_l1_dcache.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/l1_dcache_pkg.sv
// l1_dcache_pkg: shared state encodings and default geometry for the L1 data cache.
package l1_dcache_pkg;
    typedef enum logic [1:0] {DC_IDLE, DC_REFILL, DC_WRITE} dc_state_e;
    localparam int DC_SETS = 16;
    localparam int DC_WORDS = 4;
    localparam int DC_MEM_LAT = 2;
endpackage

// File: rtl/l1_dcache_array.sv
// l1_dcache_array: tag/valid/data storage, one line read combinationally per cycle.
module l1_dcache_array
    import l1_dcache_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int WORDS = DC_WORDS,
    localparam int IB = $clog2(SETS),
    localparam int OB = $clog2(WORDS),
    localparam int TW = 12 - IB - OB
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [IB-1:0]          index,
    output logic                   rd_valid,
    output logic [TW-1:0]          rd_tag,
    output logic [WORDS-1:0][31:0] rd_line,
    input  logic                   word_we,
    input  logic [OB-1:0]          word_off,
    input  logic [31:0]            word_data,
    input  logic                   line_we,
    input  logic [TW-1:0]          line_tag
);
    logic [SETS-1:0]          valid;
    logic [TW-1:0]            tags [SETS];
    logic [WORDS-1:0][31:0]   data [SETS];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) valid <= '0;
        else if (line_we) valid[index] <= 1'b1;
    end
    always_ff @(posedge clock) begin
        if (word_we) data[index][word_off] <= word_data;
        if (line_we) tags[index] <= line_tag;
    end
    assign rd_valid = valid[index];
    assign rd_tag = tags[index];
    assign rd_line = data[index];
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-through no-write-allocate L1 data cache with word-serial refill.
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int WORDS = DC_WORDS,
    parameter int MEM_LAT = DC_MEM_LAT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    localparam int IB = $clog2(SETS);
    localparam int OB = $clog2(WORDS);
    localparam int TW = 12 - IB - OB;
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    dc_state_e state, state_n;
    logic [OB-1:0] word_cnt, word_n, word_off;
    logic [LW-1:0] lat_cnt, lat_n;
    logic [OB-1:0] offset;
    logic [IB-1:0] index;
    logic [TW-1:0] tag, rd_tag;
    logic rd_valid, hit, lat_last, word_we, line_we;
    logic [WORDS-1:0][31:0] rd_line;
    logic [31:0] word_data;
    assign offset = cpu_addr[OB-1:0];
    assign index = cpu_addr[OB+IB-1:OB];
    assign tag = cpu_addr[11:OB+IB];
    assign hit = rd_valid && rd_tag == tag;
    assign lat_last = lat_cnt == LW'(MEM_LAT - 1);
    l1_dcache_array #(.SETS(SETS), .WORDS(WORDS)) u_array (
        .clock(clock), .reset(reset), .index(index),
        .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_line(rd_line),
        .word_we(word_we), .word_off(word_off), .word_data(word_data),
        .line_we(line_we), .line_tag(tag)
    );
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= DC_IDLE;
            word_cnt <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_n;
            word_cnt <= word_n;
            lat_cnt <= lat_n;
        end
    end
    always_comb begin
        state_n = state;
        word_n = word_cnt;
        lat_n = lat_cnt;
        cpu_stall = 1'b0;
        cpu_dout = '0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        mem_addr = '0;
        mem_din = '0;
        word_we = 1'b0;
        word_off = offset;
        word_data = cpu_din;
        line_we = 1'b0;
        case (state)
            DC_IDLE: if (cpu_ren ^ cpu_wen) begin
                cpu_stall = 1'b1;
                word_n = '0;
                lat_n = '0;
                if (cpu_wen) begin
                    state_n = DC_WRITE;
                    word_we = hit;
                end else if (hit) begin
                    cpu_stall = 1'b0;
                    cpu_dout = rd_line[offset];
                end else state_n = DC_REFILL;
            end
            DC_REFILL: begin
                cpu_stall = 1'b1;
                mem_ren = 1'b1;
                mem_addr = 32'({tag, index, word_cnt});
                word_off = word_cnt;
                word_data = mem_dout;
                lat_n = lat_last ? '0 : lat_cnt + LW'(1);
                if (lat_last) begin
                    word_we = 1'b1;
                    word_n = word_cnt + OB'(1);
                    // the final word completes the line, so it becomes valid on the same edge
                    if (word_cnt == OB'(WORDS - 1)) begin
                        line_we = 1'b1;
                        state_n = DC_IDLE;
                    end
                end
            end
            DC_WRITE: begin
                mem_wen = 1'b1;
                mem_addr = cpu_addr;
                mem_din = cpu_din;
                cpu_stall = !lat_last;
                lat_n = lat_last ? '0 : lat_cnt + LW'(1);
                state_n = lat_last ? DC_IDLE : DC_WRITE;
            end
            default: state_n = DC_IDLE;
        endcase
        if (!reset) begin
            cpu_stall = 1'b0;
            cpu_dout = '0;
            word_we = 1'b0;
        end
    end
`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && state == DC_IDLE && cpu_ren && cpu_wen)
            $display("l1_dcache error: simultaneous load and store at %h ignored", cpu_addr);
        if (reset && (cpu_ren || cpu_wen) && cpu_addr[31:12] != '0)
            $display("l1_dcache warning: address %h exceeds 12-bit word space", cpu_addr);
    end
`endif
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed checks of refill timing, hits, write-through, conflicts and reset.
module tb_l1_dcache;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_ren = 1'b0, cpu_wen = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_din = '0;
    logic [31:0] cpu_dout, mem_addr, mem_din, mem_dout;
    logic        cpu_stall, mem_ren, mem_wen;
    logic [31:0] mem [0:4095];
    int          n_tests = 0, n_fail = 0;
    int          stalls, wens, rens;
    logic [31:0] rd, wa;
    logic [31:0] addr_log [0:63];

    l1_dcache dut (
        .clock(clock), .reset(reset), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;
    assign mem_dout = mem[mem_addr[11:0]];
    always @(posedge clock) if (mem_wen) mem[mem_addr[11:0]] <= mem_din;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a);
        cpu_ren = 1'b1;
        cpu_addr = a;
        #1;
        stalls = 0;
        rens = 0;
        while (cpu_stall && stalls < 50) begin
            addr_log[stalls] = mem_addr;
            if (mem_ren) rens++;
            step();
            stalls++;
        end
        if (mem_ren) rens++;
        rd = cpu_dout;
        step();
        cpu_ren = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        cpu_wen = 1'b1;
        cpu_addr = a;
        cpu_din = d;
        #1;
        stalls = 0;
        wens = 0;
        wa = '0;
        while (cpu_stall && stalls < 50) begin
            if (mem_wen) begin wens++; wa = mem_addr; end
            step();
            stalls++;
        end
        if (mem_wen) begin wens++; wa = mem_addr; end
        step();
        cpu_wen = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[12'h040 + i] = 32'hA0 + i;
            mem[12'h140 + i] = 32'hB0 + i;
            mem[12'h080 + i] = 32'hC0 + i;
        end
        cpu_ren = 1'b1;
        cpu_addr = 32'h41;
        step();
        step();
        chk("reset_stall", 32'(cpu_stall), 0);
        chk("reset_dout", cpu_dout, 0);
        chk("reset_mem_ren", 32'(mem_ren), 0);
        chk("reset_mem_addr", mem_addr, 0);
        cpu_ren = 1'b0;
        reset = 1'b1;
        step();

        do_read(32'h41);
        chk("cold_stalls", stalls, 9);
        chk("cold_data", rd, 32'hA1);
        chk("cold_mem_reads", rens, 8);
        for (int k = 0; k < 8; k++) chk("cold_mem_addr", addr_log[1 + k], 32'h40 + k / 2);

        do_read(32'h43);
        chk("hit_stalls", stalls, 0);
        chk("hit_data", rd, 32'hA3);
        chk("hit_mem_ren", rens, 0);

        do_write(32'h42, 32'hDEAD);
        chk("wr_hit_stalls", stalls, 2);
        chk("wr_hit_wen_cycles", wens, 2);
        chk("wr_hit_mem_addr", wa, 32'h42);
        do_read(32'h42);
        chk("wr_hit_read_stalls", stalls, 0);
        chk("wr_hit_read_data", rd, 32'hDEAD);
        chk("wr_hit_memory", mem[12'h042], 32'hDEAD);

        do_write(32'h142, 32'h55);
        chk("wr_miss_stalls", stalls, 2);
        chk("wr_miss_memory", mem[12'h142], 32'h55);
        do_read(32'h41);
        chk("no_alloc_stalls", stalls, 0);
        chk("no_alloc_data", rd, 32'hA1);
        do_read(32'h140);
        chk("conflict_stalls", stalls, 9);
        chk("conflict_data", rd, 32'hB0);
        do_read(32'h142);
        chk("conflict_hit_stalls", stalls, 0);
        chk("conflict_hit_data", rd, 32'h55);
        do_read(32'h41);
        chk("evicted_stalls", stalls, 9);
        chk("evicted_data", rd, 32'hA1);

        cpu_ren = 1'b1;
        cpu_addr = 32'h80;
        #1;
        repeat (4) step();
        chk("mid_refill_stall", 32'(cpu_stall), 1);
        chk("mid_refill_addr", mem_addr, 32'h81);
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(cpu_stall), 0);
        chk("rst_mid_mem_ren", 32'(mem_ren), 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        chk("rst_mid_dout", cpu_dout, 0);
        step();
        cpu_ren = 1'b0;
        reset = 1'b1;
        step();
        do_read(32'h80);
        chk("post_rst_stalls", stalls, 9);
        chk("post_rst_data", rd, 32'hC0);

        cpu_ren = 1'b1;
        cpu_wen = 1'b1;
        cpu_addr = 32'h41;
        cpu_din = 32'h77;
        #1;
        chk("illegal_stall", 32'(cpu_stall), 0);
        chk("illegal_mem_ren", 32'(mem_ren), 0);
        chk("illegal_mem_wen", 32'(mem_wen), 0);
        step();
        chk("illegal_stall_next", 32'(cpu_stall), 0);
        chk("illegal_mem_wen_next", 32'(mem_wen), 0);
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        step();
        chk("illegal_memory", mem[12'h041], 32'hA1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
